// File: rtl/power_axi4_lite_slave.sv
// power_axi4_lite_slave: AXI4-Lite register block around a fixed-latency
// square-and-multiply power engine computing P = X^A.
module power_axi4_lite_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h7C80_0000,
  parameter int          X_WIDTH   = 8,
  parameter int          A_WIDTH   = 8,
  parameter int          P_WIDTH   = 32
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic        o_irq
);
  localparam int CW = $clog2(A_WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_e;
  state_e             state_q;
  logic               awready_q, arready_q, bvalid_q, rvalid_q;
  logic [1:0]         bresp_q, rresp_q;
  logic [31:0]        rdata_q;
  logic [X_WIDTH-1:0] x_q;
  logic [A_WIDTH-1:0] a_q, exp_q;
  logic               irq_en_q, done_q, busy_q, ovf_q, base_ovf_q;
  logic [P_WIDTH-1:0] p_q, result_q, base_q, result_d;
  logic [CW-1:0]      cnt_q;
  logic [31:0]        w_off, r_off, rdata_d, x_d, a_d;
  logic               wr_en, rd_en, lane0, start, w1c, last, ovf_d;
  logic [2*P_WIDTH-1:0] mul_r, mul_b;
  function automatic logic is_reg(input logic [31:0] off);
    return off == 32'h00 || off == 32'h04 || off == 32'h08 || off == 32'h0C || off == 32'h10;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = st[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction
  assign w_off    = S_AXI_AWADDR - BASE_ADDR;
  assign r_off    = S_AXI_ARADDR - BASE_ADDR;
  assign wr_en    = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en    = arready_q & S_AXI_ARVALID;
  assign lane0    = S_AXI_WSTRB[0];
  assign start    = wr_en && w_off == 32'h08 && lane0 && S_AXI_WDATA[0] && state_q == IDLE;
  assign w1c      = wr_en && w_off == 32'h10 && lane0 && S_AXI_WDATA[0];
  assign x_d      = merge(32'(x_q), S_AXI_WDATA, S_AXI_WSTRB);
  assign a_d      = merge(32'(a_q), S_AXI_WDATA, S_AXI_WSTRB);
  assign rdata_d  = r_off == 32'h00 ? 32'(x_q) :
                    r_off == 32'h04 ? 32'(a_q) :
                    r_off == 32'h08 ? {30'd0, irq_en_q, 1'b0} :
                    r_off == 32'h0C ? 32'(p_q) :
                    r_off == 32'h10 ? {29'd0, ovf_q, busy_q, done_q} : 32'd0;
  // Full-width products expose the bits lost to truncation for overflow detection.
  assign mul_r    = (2*P_WIDTH)'(result_q) * (2*P_WIDTH)'(base_q);
  assign mul_b    = (2*P_WIDTH)'(base_q) * (2*P_WIDTH)'(base_q);
  assign result_d = exp_q[0] ? mul_r[P_WIDTH-1:0] : result_q;
  assign ovf_d    = ovf_q | (exp_q[0] & ((|mul_r[2*P_WIDTH-1:P_WIDTH]) | base_ovf_q));
  assign last     = cnt_q == CW'(A_WIDTH - 1);
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign o_irq         = done_q & irq_en_q;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      awready_q  <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      x_q        <= '0;
      a_q        <= '0;
      irq_en_q   <= 1'b0;
      p_q        <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      base_ovf_q <= 1'b0;
      result_q   <= '0;
      base_q     <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
    end else begin
      awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
      arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      if (wr_en) begin
        bvalid_q <= 1'b1;
        bresp_q  <= is_reg(w_off) ? 2'b00 : 2'b10;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= is_reg(r_off) ? 2'b00 : 2'b10;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      if (wr_en && w_off == 32'h00) x_q <= x_d[X_WIDTH-1:0];
      if (wr_en && w_off == 32'h04) a_q <= a_d[A_WIDTH-1:0];
      if (wr_en && w_off == 32'h08 && lane0) irq_en_q <= S_AXI_WDATA[1];
      // Completion below is assigned later, so it wins over a same-cycle clear.
      if (w1c) done_q <= 1'b0;
      if (start) begin
        state_q    <= RUN;
        result_q   <= P_WIDTH'(1);
        base_q     <= P_WIDTH'(x_q);
        exp_q      <= a_q;
        cnt_q      <= '0;
        base_ovf_q <= 1'b0;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        ovf_q      <= 1'b0;
      end else if (state_q == RUN) begin
        result_q   <= result_d;
        base_q     <= mul_b[P_WIDTH-1:0];
        base_ovf_q <= base_ovf_q | (|mul_b[2*P_WIDTH-1:P_WIDTH]);
        exp_q      <= exp_q >> 1;
        cnt_q      <= cnt_q + CW'(1);
        ovf_q      <= ovf_d;
        if (last) begin
          state_q <= IDLE;
          p_q     <= result_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_power_axi4_lite_slave.sv
// tb_power_axi4_lite_slave: directed and random AXI4-Lite traffic against the
// power engine, checked with an arbitrary-precision style X^A reference.
module tb_power_axi4_lite_slave;
  localparam logic [31:0] BASE = 32'h7C80_0000;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  int vectors = 0, miscompares = 0;

  power_axi4_lite_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .o_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // x^a mod 2^32 plus a flag telling whether the true value needs more than 32 bits.
  function automatic void model(input int unsigned x, input int unsigned a,
                                output logic [31:0] p, output logic o);
    longint unsigned big = 1, pp = 1;
    o = 1'b0;
    for (int i = 0; i < int'(a); i++) begin
      pp  = (pp * x) & 64'hFFFF_FFFF;
      big = big * x;
      if (big >= 64'h1_0000_0000) begin
        o   = 1'b1;
        big = 64'h1_0000_0000;
      end
    end
    p = pp[31:0];
  endfunction

  task automatic axi_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp);
    int n = 0;
    awaddr = BASE + off; wdata = d; wstrb = st; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    chk("awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid", 32'(bvalid), 32'd1);
    resp = bresp;
  endtask

  task automatic axi_read(input logic [31:0] off, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    araddr = BASE + off; arvalid = 1'b1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    chk("arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid", 32'(rvalid), 32'd1);
    d = rdata; resp = rresp;
  endtask

  task automatic run_pow(input logic [7:0] x, input logic [7:0] a);
    logic [1:0] r; logic [31:0] d, ep; logic eo; int n = 0;
    model(x, a, ep, eo);
    axi_write(32'h00, 32'(x), 4'hF, r);
    axi_write(32'h04, 32'(a), 4'hF, r);
    axi_write(32'h08, 32'd3, 4'h1, r);
    chk("start_bresp", 32'(r), 32'd0);
    while (!irq && n < 100) begin @(posedge clk); #1; n++; end
    chk("latency", n, 32'd8);
    axi_read(32'h0C, d, r);
    chk("P", d, ep);
    axi_read(32'h10, d, r);
    chk("STATUS", d, 32'({eo, 2'b01}));
    axi_write(32'h10, 32'd1, 4'h1, r);
    chk("irq_after_w1c", 32'(irq), 32'd0);
  endtask

  initial begin
    logic [1:0] r; logic [31:0] d; logic aw_hs, ar_hs; int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {awready, wready, arready}, 32'd0);
    chk("rst_valid", {bvalid, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", {bresp, rresp}, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(32'h00, d, r); chk("rst_X", d, 32'd0);
    axi_read(32'h0C, d, r); chk("rst_P", d, 32'd0);
    axi_read(32'h10, d, r); chk("rst_STATUS", d, 32'd0);

    run_pow(8'd3, 8'd4);
    run_pow(8'd2, 8'd32);
    run_pow(8'd2, 8'd31);
    run_pow(8'd0, 8'd0);
    run_pow(8'd0, 8'd7);
    run_pow(8'd1, 8'd255);
    run_pow(8'd255, 8'd255);
    for (int i = 0; i < 8; i++)
      run_pow(8'($urandom_range(0, 255)), i < 4 ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255)));

    // Second start during RUN with a new X must be ignored.
    axi_write(32'h00, 32'd3, 4'hF, r);
    axi_write(32'h04, 32'd4, 4'hF, r);
    axi_write(32'h08, 32'd3, 4'h1, r);
    axi_write(32'h00, 32'd5, 4'hF, r);
    axi_write(32'h08, 32'd3, 4'h1, r);
    chk("restart_bresp", 32'(r), 32'd0);
    n = 0;
    while (!irq && n < 100) begin @(posedge clk); #1; n++; end
    chk("restart_irq", 32'(irq), 32'd1);
    axi_read(32'h0C, d, r); chk("restart_P", d, 32'd81);
    axi_read(32'h00, d, r); chk("restart_X", d, 32'd5);
    axi_write(32'h10, 32'd1, 4'h1, r);
    repeat (30) @(posedge clk);
    #1;
    chk("single_done", 32'(irq), 32'd0);

    // Simultaneous unmapped write and mapped read with stalled responses.
    bready = 1'b0; rready = 1'b0;
    awaddr = BASE + 32'h18; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = BASE; arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aw_hs = awready; ar_hs = arready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (ar_hs) arvalid = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", 32'(bvalid), 32'd1);
      chk("stall_bresp", 32'(bresp), 32'd2);
      chk("stall_rvalid", 32'(rvalid), 32'd1);
      chk("stall_rdata", rdata, 32'd5);
      chk("stall_rresp", 32'(rresp), 32'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", {bvalid, rvalid}, 32'd0);

    axi_write(32'h00, 32'hAB, 4'h0, r);
    axi_read(32'h00, d, r); chk("strb0_X", d, 32'd5);
    axi_write(32'h08, 32'd1, 4'h0, r);
    axi_read(32'h10, d, r); chk("strb0_nostart", d, 32'd0);
    axi_write(32'h00, 32'h77, 4'h1, r);
    axi_read(32'h00, d, r); chk("strb1_X", d, 32'h77);
    axi_write(32'h20, 32'd1, 4'hF, r); chk("oob_hi_bresp", 32'(r), 32'd2);
    axi_write(32'hFFFF_FFFC, 32'd1, 4'hF, r); chk("oob_lo_bresp", 32'(r), 32'd2);
    axi_read(32'h00, d, r); chk("oob_noeffect", d, 32'h77);
    axi_read(32'h14, d, r);
    chk("rd14_rresp", 32'(r), 32'd2); chk("rd14_rdata", d, 32'd0);
    axi_read(32'h0D, d, r); chk("unaligned_rresp", 32'(r), 32'd2);
    axi_read(32'h08, d, r); chk("CTRL", d, 32'd2);
    axi_write(32'h0C, 32'd9, 4'hF, r); chk("ro_bresp", 32'(r), 32'd0);
    axi_read(32'h0C, d, r); chk("ro_P", d, 32'd81);

    // Reset in the middle of a computation.
    axi_write(32'h00, 32'd3, 4'hF, r);
    axi_write(32'h08, 32'd1, 4'h1, r);
    axi_read(32'h10, d, r); chk("busy", d, 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {awready, wready, arready}, 32'd0);
    chk("mid_rst_valid", {bvalid, rvalid}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_resp", {bresp, rresp}, 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(32'h00, d, r); chk("post_rst_X", d, 32'd0);
    axi_read(32'h04, d, r); chk("post_rst_A", d, 32'd0);
    axi_read(32'h08, d, r); chk("post_rst_CTRL", d, 32'd0);
    axi_read(32'h0C, d, r); chk("post_rst_P", d, 32'd0);
    axi_write(32'h08, 32'd2, 4'h1, r);
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_irq", 32'(irq), 32'd0);
    axi_read(32'h10, d, r); chk("post_rst_STATUS", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/power_axi4_lite_slave.md
POWER_AXI4_LITE_SLAVE -- requirements
Module: power_axi4_lite_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h7C800000, base of the 32-byte register window.
REQ-002 Parameter X_WIDTH, default 8, operand X width (1..32).
REQ-003 Parameter A_WIDTH, default 8, exponent A width (1..32); also the fixed iteration count.
REQ-004 Parameter P_WIDTH, default 32, result P width (X_WIDTH..32).
REQ-005 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-006 S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-007 S_AXI_AWADDR in 32, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-008 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-009 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-010 S_AXI_ARADDR in 32, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-011 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-012 o_irq  out  1  level interrupt = STATUS.done AND CTRL.irq_en.

Function
REQ-013 Map (offset from BASE_ADDR): 0x00 X RW [X_WIDTH-1:0]; 0x04 A RW [A_WIDTH-1:0]; 0x08 CTRL: bit0 start (write-1 pulse, reads 0), bit1 irq_en RW; 0x0C P RO [P_WIDTH-1:0]; 0x10 STATUS: bit0 done (W1C), bit1 busy RO, bit2 overflow RO.
REQ-014 Unused register bits read 0; any address outside the five offsets, or outside BASE_ADDR..BASE_ADDR+0x1F, returns SLVERR (2'b10), RDATA 0, no state change; mapped accesses return OKAY; writes to RO registers are OKAY and ignored.
REQ-015 Writes honour WSTRB per byte lane; start and W1C act only when lane 0 strobe set.
REQ-016 Write: AWREADY and WREADY pulse together for one cycle when AWVALID and WVALID both high and BVALID low; register update in that cycle; BVALID next cycle, held until BREADY.
REQ-017 Read: ARREADY pulses one cycle when ARVALID high and RVALID low; RDATA/RRESP registered next cycle with RVALID, held stable until RREADY.
REQ-018 Read and write channels operate independently; simultaneous read and write in the same cycle both complete.
REQ-019 Engine states IDLE, RUN; start accepted only in IDLE; start in RUN ignored, response OKAY.
REQ-020 On start: latch X, A; result=1, base=X, exp=A, cnt=0, busy=1, done=0, overflow=0; go RUN.
REQ-021 RUN per cycle: if exp[0], result=result*base truncated to P_WIDTH; base=base*base truncated; exp>>=1; cnt++.
REQ-022 Sticky base_ovf set when square exceeds P_WIDTH bits; overflow set when a result multiply exceeds P_WIDTH bits or uses base with base_ovf set.
REQ-023 RUN lasts exactly A_WIDTH cycles; done=1, busy=0, P=result on the following edge, return IDLE; latency independent of operand values.
REQ-024 0^0 = 1; X=0, A>0 gives 0, no overflow.
REQ-025 X/A writes during RUN update registers but not the running computation.
REQ-026 Engine completion and W1C of done in the same cycle: done remains 1.
REQ-027 P holds last result until next completion.

Reset
REQ-028 On ARESETN low, asynchronously: all READY/VALID outputs 0, RDATA 0, BRESP/RRESP 0, X=0, A=0, irq_en=0, P=0, done=0, busy=0, overflow=0, engine IDLE, o_irq=0.
REQ-029 Reset mid-RUN aborts computation; after release no done asserts without a new start.

Verification
REQ-030 Write X=3, A=4, CTRL=1 -> busy for 8 cycles, then done=1, P=81, overflow=0.
REQ-031 X=2, A=32 (defaults) -> P=0, overflow=1; X=2, A=31 -> P=32'h80000000, overflow=0.
REQ-032 X=0, A=0 -> P=1; irq_en=1 -> o_irq=1; W1C STATUS=1 -> done=0, o_irq=0.
REQ-033 Start then second start 2 cycles later with X changed -> single completion, P from first operands.
REQ-034 Read 0x14 and write 0x18 -> RRESP/BRESP=2'b10, RDATA=0; BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data stay stable.
REQ-035 Reset asserted 3 cycles into RUN -> all outputs at reset values immediately; no done afterward.
